// File: rtl/keccak_sponge_ctrl_if.sv
// Absorb-bus and squeeze-stream signals between the sponge controller and its
// neighbours. The controller takes the master modport; the padder/sink take slave.
interface keccak_sponge_ctrl_if;
    logic        blk_valid;
    logic        blk_last;
    logic        blk_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    modport master (
        input  blk_valid,
        input  blk_last,
        input  dout_ready,
        output blk_ready,
        output dout,
        output dout_valid,
        output dout_last
    );

    modport slave (
        output blk_valid,
        output blk_last,
        output dout_ready,
        input  blk_ready,
        input  dout,
        input  dout_valid,
        input  dout_last
    );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge sequencer: clears and absorbs padded rate blocks, schedules the
// 24-round permutation and squeezes the digest as flow-controlled 32-bit words,
// re-permuting whenever a rate block of output has been consumed.
module keccak_sponge_ctrl #(
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [2:0]                 cmode_i,
    input  logic [10:0]                d_i,
    input  logic [1599:0]              state_in_i,
    output logic                       st_clear_o,
    output logic                       st_absorb_o,
    output logic                       rnd_en_o,
    output logic [4:0]                 rnd_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    keccak_sponge_ctrl_if.master       sponge_if
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAbsorb  = 3'd1;
    localparam logic [2:0] StPermute = 3'd2;
    localparam logic [2:0] StSqueeze = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    // Widest rate (SHAKE128) in 32-bit words; higher lanes are capacity.
    localparam int unsigned MaxRateWords = 42;
    localparam logic [4:0]  LastRound    = 5'(NUM_ROUNDS - 1);

    logic [2:0] state_q, state_d;
    logic [4:0] rnd_q, rnd_d;
    logic [5:0] wptr_q, wptr_d;
    logic [5:0] ocnt_q, ocnt_d;
    logic [5:0] rate_q, rate_d;
    logic [5:0] outw_q, outw_d;
    logic       last_q, last_d;
    logic       err_q, err_d;

    logic        mode_ok;
    logic [5:0]  rate_sel;
    logic [5:0]  outw_sel;
    logic        start_ok;
    logic        word_last;
    logic [WORD_W-1:0] lane_word;
    logic [WORD_W-1:0] dout_word;

    // Only the rate part of the state is ever squeezed; SHAKE length is in whole words.
    logic unused_in;
    assign unused_in = ^{state_in_i[1599:WORD_W*MaxRateWords], d_i[4:0]};

    // Mode table: rate and digest length in words for the requested cmode.
    always_comb begin
        mode_ok  = 1'b1;
        rate_sel = 6'd0;
        outw_sel = 6'd0;
        unique case (cmode_i)
            3'd0: begin rate_sel = 6'd36; outw_sel = 6'd7;     end
            3'd1: begin rate_sel = 6'd34; outw_sel = 6'd8;     end
            3'd2: begin rate_sel = 6'd26; outw_sel = 6'd12;    end
            3'd3: begin rate_sel = 6'd18; outw_sel = 6'd16;    end
            3'd4: begin rate_sel = 6'd42; outw_sel = d_i[10:5]; end
            3'd5: begin rate_sel = 6'd34; outw_sel = d_i[10:5]; end
            default: mode_ok = 1'b0;
        endcase
    end

    assign start_ok  = (state_q == StIdle) && start_i && mode_ok;
    assign word_last = (ocnt_q == outw_q - 6'd1);

    // Next-state and counter update for the sponge schedule.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        wptr_d  = wptr_q;
        ocnt_d  = ocnt_q;
        rate_d  = rate_q;
        outw_d  = outw_q;
        last_d  = last_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (mode_ok) begin
                        state_d = StAbsorb;
                        rate_d  = rate_sel;
                        outw_d  = outw_sel;
                        rnd_d   = 5'd0;
                        wptr_d  = 6'd0;
                        ocnt_d  = 6'd0;
                        last_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StAbsorb: begin
                if (sponge_if.blk_valid) begin
                    state_d = StPermute;
                    last_d  = sponge_if.blk_last;
                    rnd_d   = 5'd0;
                end
            end
            StPermute: begin
                if (rnd_q == LastRound) begin
                    rnd_d = 5'd0;
                    if (!last_q) begin
                        state_d = StAbsorb;
                    end else if (outw_q == 6'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSqueeze;
                        wptr_d  = 6'd0;
                    end
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            StSqueeze: begin
                if (sponge_if.dout_ready) begin
                    ocnt_d = ocnt_q + 6'd1;
                    wptr_d = wptr_q + 6'd1;
                    if (word_last) begin
                        state_d = StDone;
                    end else if (wptr_q == rate_q - 6'd1) begin
                        // Rate block exhausted: permute again, keep last_f set.
                        state_d = StPermute;
                        rnd_d   = 5'd0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rnd_q   <= 5'd0;
            wptr_q  <= 6'd0;
            ocnt_q  <= 6'd0;
            rate_q  <= 6'd0;
            outw_q  <= 6'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            wptr_q  <= wptr_d;
            ocnt_q  <= ocnt_d;
            rate_q  <= rate_d;
            outw_q  <= outw_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Select the current 32-bit rate word.
    always_comb begin
        lane_word = '0;
        for (int i = 0; i < MaxRateWords; i++) begin
            if (wptr_q == 6'(i)) begin
                lane_word = state_in_i[WORD_W*i +: WORD_W];
            end
        end
    end

    // Byte 0 of the word goes out in the top byte.
    always_comb begin
        dout_word = {lane_word[7:0], lane_word[15:8], lane_word[23:16], lane_word[31:24]};
    end

    // Output decodes from the registered state; dout_ready never reaches dout_valid.
    always_comb begin
        st_clear_o           = rst_n && start_ok;
        st_absorb_o          = (state_q == StAbsorb) && sponge_if.blk_valid;
        rnd_en_o             = (state_q == StPermute);
        rnd_idx_o            = (state_q == StPermute) ? rnd_q : 5'd0;
        busy_o               = (state_q != StIdle);
        done_o               = (state_q == StDone);
        err_o                = err_q;
        sponge_if.blk_ready  = (state_q == StAbsorb);
        sponge_if.dout_valid = (state_q == StSqueeze);
        sponge_if.dout       = (state_q == StSqueeze) ? dout_word : '0;
        sponge_if.dout_last  = (state_q == StSqueeze) && word_last;
    end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Scoreboard bench for keccak_sponge_ctrl: stimulus pushes the expected event
// stream, a negedge monitor pops and compares each observed strobe and word.
module tb_keccak_sponge_ctrl;

    localparam int EvClr  = 0;
    localparam int EvAbs  = 1;
    localparam int EvRnd  = 2;
    localparam int EvWord = 3;
    localparam int EvDone = 4;
    localparam int EvErr  = 5;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        last;
    } evt_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } dchk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cmode = 3'd0;
    logic [10:0]   d = 11'd0;
    logic [1599:0] state_in = '0;
    logic          st_clear, st_absorb, rnd_en, busy, done, err;
    logic [4:0]    rnd_idx;
    logic          rand_ready = 1'b0;

    keccak_sponge_ctrl_if sif ();

    keccak_sponge_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .cmode_i     (cmode),
        .d_i         (d),
        .state_in_i  (state_in),
        .st_clear_o  (st_clear),
        .st_absorb_o (st_absorb),
        .rnd_en_o    (rnd_en),
        .rnd_idx_o   (rnd_idx),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .sponge_if   (sif)
    );

    always #5 clk = ~clk;

    evt_t  exp_q[$];
    dchk_t dq[$];
    int    n_checks = 0;
    int    n_fails = 0;
    int    seed = 0;

    function automatic string kname(input int k);
        case (k)
            EvClr:   return "st_clear";
            EvAbs:   return "st_absorb";
            EvRnd:   return "rnd_en";
            EvWord:  return "dout_word";
            EvDone:  return "done";
            default: return "err";
        endcase
    endfunction

    function automatic logic [7:0] sbyte(input int k);
        return 8'((k * 37 + seed * 11 + 5) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int wp);
        return {sbyte(4 * wp), sbyte(4 * wp + 1), sbyte(4 * wp + 2), sbyte(4 * wp + 3)};
    endfunction

    task automatic set_state(input int s);
        seed = s;
        for (int k = 0; k < 200; k++) state_in[8 * k +: 8] = sbyte(k);
    endtask

    task automatic push_evt(input int kind, input logic [31:0] data, input logic last);
        evt_t e;
        e.kind = kind;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_rounds(input int n);
        for (int r = 0; r < n; r++) push_evt(EvRnd, 32'(r), 1'b0);
    endtask

    task automatic dcheck(input string name, input logic [63:0] act, input logic [63:0] exp);
        dchk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        dq.push_back(c);
    endtask

    // Expected event stream for a complete job.
    task automatic push_job(input int cm, input int dlen, input int nblk);
        int rate_t[6] = '{36, 34, 26, 18, 42, 34};
        int outw_t[4] = '{7, 8, 12, 16};
        int rate;
        int outw;
        int wp;
        rate = rate_t[cm];
        outw = (cm < 4) ? outw_t[cm] : (dlen / 32);
        push_evt(EvClr, 32'd0, 1'b0);
        for (int b = 0; b < nblk; b++) begin
            push_evt(EvAbs, 32'd0, 1'b0);
            push_rounds(24);
        end
        for (int i = 0; i < outw; i++) begin
            wp = i % rate;
            if (i > 0 && wp == 0) push_rounds(24);
            push_evt(EvWord, exp_word(wp), (i == outw - 1));
        end
        push_evt(EvDone, 32'd0, 1'b0);
    endtask

    task automatic start_job(input int cm, input int dlen);
        @(posedge clk);
        #1;
        start = 1'b1;
        cmode = 3'(cm);
        d     = 11'(dlen);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_blocks(input int nblk, input int gap, input bit poke);
        int n;
        for (int b = 0; b < nblk; b++) begin
            n = 0;
            while (!sif.blk_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!sif.blk_ready) dcheck("blk_ready_timeout", 64'(sif.blk_ready), 64'd1);
            repeat (gap) @(posedge clk);
            #1;
            sif.blk_valid = 1'b1;
            sif.blk_last  = (b == nblk - 1);
            @(posedge clk);
            #1;
            sif.blk_valid = 1'b0;
            sif.blk_last  = 1'b0;
            if (poke && b == 0) begin
                // Start and a stray block while permuting must both be ignored.
                repeat (3) @(posedge clk);
                #1;
                start         = 1'b1;
                cmode         = 3'd3;
                sif.blk_valid = 1'b1;
                sif.blk_last  = 1'b1;
                dcheck("blk_ready_in_permute", 64'(sif.blk_ready), 64'd0);
                @(posedge clk);
                #1;
                start         = 1'b0;
                sif.blk_valid = 1'b0;
                sif.blk_last  = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            dcheck("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
        #1;
        dcheck("busy_after_done", 64'(busy), 64'd0);
        dcheck("done_is_pulse", 64'(done), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({st_clear, st_absorb, rnd_en, rnd_idx, busy, done, err, sif.blk_ready,
                    sif.dout_valid, sif.dout_last, sif.dout});
    endfunction

    // Ready source: always ready, or random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        sif.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor and scoreboard.
    logic        stall_prev = 1'b0;
    logic [31:0] stall_dout = '0;
    logic        stall_last = 1'b0;
    logic        evt_prev = 1'b0;
    logic        evt_now;
    dchk_t       c;
    evt_t        e;

    task automatic chk_evt(input int kind, input logic [31:0] data, input logic last);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_%s: got data %0h last %0b, expected no event",
                     kname(kind), data, last);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.last !== last) begin
                n_fails++;
                $display("FAIL event_%s: got %s data %0h last %0b, expected %s data %0h last %0b",
                         kname(e.kind), kname(kind), data, last, kname(e.kind), e.data, e.last);
            end
        end
    endtask

    always @(negedge clk) begin
        while (dq.size() != 0) begin
            c = dq.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_fails++;
                $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
            end
        end
        if (rst_n) begin
            if (stall_prev) begin
                n_checks++;
                if (!sif.dout_valid || sif.dout !== stall_dout || sif.dout_last !== stall_last) begin
                    n_fails++;
                    $display("FAIL stall_hold: got valid %0b dout %0h last %0b, expected 1 %0h %0b",
                             sif.dout_valid, sif.dout, sif.dout_last, stall_dout, stall_last);
                end
            end
            if (st_clear)  chk_evt(EvClr, 32'd0, 1'b0);
            if (st_absorb) chk_evt(EvAbs, 32'd0, 1'b0);
            if (rnd_en)    chk_evt(EvRnd, 32'(rnd_idx), 1'b0);
            if (sif.dout_valid && sif.dout_ready) chk_evt(EvWord, sif.dout, sif.dout_last);
            if (done) begin
                chk_evt(EvDone, 32'd0, 1'b0);
                n_checks++;
                if (!evt_prev) begin
                    n_fails++;
                    $display("FAIL done_timing: got gap before done, expected done right after last event");
                end
            end
            if (err) chk_evt(EvErr, 32'd0, 1'b0);
            evt_now    = rnd_en || (sif.dout_valid && sif.dout_ready);
            evt_prev   = evt_now;
            stall_prev = sif.dout_valid && !sif.dout_ready;
            stall_dout = sif.dout;
            stall_last = sif.dout_last;
        end else begin
            stall_prev = 1'b0;
            evt_prev   = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.blk_valid = 1'b0;
        sif.blk_last  = 1'b0;
        #2;
        dcheck("reset_outputs", all_outs(), 64'd0);
        #20;
        rst_n = 1'b1;

        // SHA3-256, one block, d ignored; start and stray block poked mid-permute.
        set_state(1);
        push_job(1, 2016, 1);
        start_job(1, 2016);
        send_blocks(1, 0, 1'b1);
        wait_drain(400);

        // SHA3-512, three blocks each delayed five cycles.
        set_state(2);
        push_job(3, 0, 3);
        start_job(3, 0);
        send_blocks(3, 5, 1'b0);
        wait_drain(400);

        // SHAKE128, 63 words spanning a squeeze permutation.
        set_state(3);
        push_job(4, 2016, 1);
        start_job(4, 2016);
        send_blocks(1, 0, 1'b0);
        wait_drain(400);

        // SHAKE256, d=31: no output words.
        set_state(4);
        push_job(5, 31, 1);
        start_job(5, 31);
        send_blocks(1, 0, 1'b0);
        wait_drain(200);

        // SHAKE256, d=100: three words.
        set_state(5);
        push_job(5, 100, 2);
        start_job(5, 100);
        send_blocks(2, 1, 1'b0);
        wait_drain(200);

        // SHA3-224 under random backpressure.
        set_state(6);
        rand_ready = 1'b1;
        push_job(0, 0, 1);
        start_job(0, 0);
        send_blocks(1, 2, 1'b0);
        wait_drain(600);
        rand_ready = 1'b0;

        // Illegal mode: err pulse only.
        push_evt(EvErr, 32'd0, 1'b0);
        start_job(7, 0);
        dcheck("busy_on_illegal", 64'(busy), 64'd0);
        wait_drain(10);

        // Reset asserted in the middle of a permutation.
        set_state(7);
        push_evt(EvClr, 32'd0, 1'b0);
        push_evt(EvAbs, 32'd0, 1'b0);
        push_rounds(5);
        start_job(1, 0);
        send_blocks(1, 0, 1'b0);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        dcheck("abort_reached", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        dcheck("abort_rnd_en", 64'(rnd_en), 64'd0);
        dcheck("abort_outputs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Clean run after the abort.
        set_state(8);
        push_job(1, 0, 1);
        start_job(1, 0);
        send_blocks(1, 0, 1'b0);
        wait_drain(400);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
- Sequencing controller for the Keccak core.
- Accepts pre-padded rate blocks and drives the state-register absorb and clear strobes.
- Runs a 24-round permutation schedule to the round datapath.
- Streams the squeezed digest as 32-bit words over a valid/ready handshake, re-permuting between rate blocks for long SHAKE outputs.
- Sits between the input buffer/padder and the 1600-bit state/round unit; replaces free-running output truncation with a flow-controlled squeeze.

Parameters:
- NUM_ROUNDS, 24, permutation rounds per Keccak-f[1600] call.
- WORD_W, 32, output word width in bits (fixed; not to be overridden).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin new hash; sampled only in IDLE
- cmode  input  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256
- d  input  11  SHAKE output length in bits; ignored for SHA3 modes
- blk_valid  input  1  padded rate block available on the absorb bus
- blk_last  input  1  qualifies blk_valid: final block of message
- blk_ready  output  1  controller accepts block this cycle
- st_clear  output  1  one-cycle pulse: zero the state register
- st_absorb  output  1  one-cycle pulse: XOR presented block into the state
- rnd_en  output  1  round datapath applies round rnd_idx this cycle
- rnd_idx  output  5  round index 0..23
- state_in  input  1600  current Keccak state (lane 0 = bits 63:0)
- dout  output  32  squeezed word
- dout_valid  output  1  dout valid
- dout_ready  input  1  sink accepts dout
- dout_last  output  1  dout is final word of digest
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after final word handshake
- err  output  1  one-cycle pulse: start with illegal cmode (6, 7)

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including dout. All counters and latched mode/length 0. Reset mid-operation aborts immediately, with no done pulse.
- Mode latch on accepted start (IDLE & start & cmode<=5): store rate_words and out_words.
  - rate_words: 36, 34, 26, 18, 42, 34 for cmode 0..5.
  - out_words: 7, 8, 12, 16 for cmode 0..3; d[10:5] for SHAKE (floor(d/32); remainder bits dropped).
- Illegal cmode at start: err pulses next cycle, FSM stays IDLE, no other output changes.
- FSM states:
  - IDLE: on accepted start, st_clear pulses in the same cycle; next state ABSORB.
  - ABSORB: blk_ready=1. On blk_valid, st_absorb pulses the same cycle, last_f <= blk_last, rnd counter <= 0; next PERMUTE.
  - PERMUTE: rnd_en=1 and rnd_idx=counter for exactly 24 consecutive cycles (0..23). After idx 23:
    - not last_f -> ABSORB.
    - last_f and out_words==0 -> DONE.
    - otherwise -> SQUEEZE.
    - wptr is cleared on every entry to SQUEEZE.
  - SQUEEZE: dout_valid=1.
    - dout = {B[4w], B[4w+1], B[4w+2], B[4w+3]}, where w=wptr and B[k]=state_in[8k+7:8k] (byte 0 in dout[31:24]).
    - dout_last = (ocnt == out_words-1).
    - On dout_valid & dout_ready: ocnt++ and wptr++, then:
      - last word -> DONE.
      - else if wptr==rate_words-1 -> PERMUTE (squeeze permutation, last_f kept) and return to SQUEEZE with wptr=0.
      - else stay in SQUEEZE.
    - dout and dout_last are held stable while dout_valid & !dout_ready.
  - DONE: done=1 for one cycle, then IDLE. busy drops in the IDLE cycle.
- start while busy: ignored. blk_valid outside ABSORB: ignored, with blk_ready=0.
- Output controls (blk_ready, st_*, rnd_*, dout*) are Moore/registered-state decodes with no combinational path from dout_ready to dout_valid.
- Counters: rnd 5-bit, wptr 6-bit, ocnt 6-bit. No wrap-around is reachable: out_words<=63 and wptr is reset at rate_words.

Test Plan:
- SHA3-256, one block (blk_last=1), dout_ready=1:
  - st_clear, then st_absorb, then 24 rnd_en cycles with idx 0..23.
  - Then exactly 8 words, with dout_last on the 8th and done one cycle later.
  - Word 0 equals state_in bytes 0..3 in that order.
- SHA3-512, 3 blocks with blk_valid delayed 5 cycles each:
  - 3 st_absorb pulses and 72 total rnd_en cycles before the first dout_valid.
  - 16 output words.
- SHAKE128, d=2016 (63 words):
  - After word 42 (wptr 41), a 24-cycle PERMUTE is inserted.
  - 21 more words follow, with dout_last on the 63rd.
- SHAKE256, d=31: out_words=0, so there are no dout_valid cycles and done pulses directly after the final permutation. With d=100, 3 words are output.
- Backpressure: dout_ready toggled randomly during SHA3-224 -> dout stable while stalled, exactly 7 handshakes, no lost or duplicated words.
- cmode=7 start -> err pulse, busy stays 0. Start pulsed while busy -> ignored. rst_n asserted during PERMUTE -> all outputs 0 asynchronously, and the next start runs cleanly.
